// File: rtl/avg_uart_tx.sv
// Queues once-per-minute temperature averages and reports each one as a
// 4-character ASCII frame "ddd\n" on a UART 8N1 line.
module avg_uart_tx #(
  parameter int CLKS_PER_BIT = 434,
  parameter int DEPTH        = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [7:0]                 avg_in,
  input  logic                       avg_valid,
  output logic                       tx,
  output logic                       busy,
  output logic [$clog2(DEPTH+1)-1:0] fifo_count,
  output logic                       overflow
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  localparam int BW = $clog2(CLKS_PER_BIT);
  localparam logic [BW-1:0] LAST_CLK = BW'(CLKS_PER_BIT - 1);

  typedef enum logic [2:0] {IDLE, CONV, START, DATA, STOP} state_t;

  state_t        state, state_n;
  logic [7:0]    mem [DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] count;
  logic          push, pop;
  logic [7:0]    val, h, t, u;
  logic [BW-1:0] clk_cnt, clk_cnt_n;
  logic [2:0]    bit_idx, bit_idx_n;
  logic [1:0]    ci, ci_n;
  logic [7:0]    ch_n;
  logic          tx_n;

  // A full FIFO still accepts a push in the cycle the FSM pops its head.
  assign pop  = (state == IDLE) && (count != '0);
  assign push = avg_valid && ((count < CW'(DEPTH)) || pop);

  assign fifo_count = count;
  assign busy       = (count != '0) || (state != IDLE);

  // NOTE: the storage array is deliberately not reset; pointers and count
  // alone define which entries are valid, so clearing them discards the data.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= avg_in;
  end

  // NOTE: sequential state is always written with <= so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      if (push && !pop)      count <= count + CW'(1);
      else if (pop && !push) count <= count - CW'(1);
      if (avg_valid && !push) overflow <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      clk_cnt <= '0;
      bit_idx <= '0;
      ci      <= '0;
      tx      <= 1'b1;
      val     <= '0;
      h       <= '0;
      t       <= '0;
      u       <= '0;
    end else begin
      state   <= state_n;
      clk_cnt <= clk_cnt_n;
      bit_idx <= bit_idx_n;
      ci      <= ci_n;
      tx      <= tx_n;
      if (pop) val <= mem[rd_ptr];
      if (state == CONV) begin
        h <= val / 8'd100;
        t <= (val / 8'd10) % 8'd10;
        u <= val % 8'd10;
      end
    end
  end

  // NOTE: every signal assigned here gets a default first, so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    state_n   = state;
    clk_cnt_n = clk_cnt;
    bit_idx_n = bit_idx;
    ci_n      = ci;
    case (state)
      IDLE: if (pop) state_n = CONV;
      CONV: begin
        state_n   = START;
        ci_n      = '0;
        clk_cnt_n = '0;
      end
      START: begin
        if (clk_cnt == LAST_CLK) begin
          clk_cnt_n = '0;
          bit_idx_n = '0;
          state_n   = DATA;
        end else begin
          clk_cnt_n = clk_cnt + BW'(1);
        end
      end
      DATA: begin
        if (clk_cnt == LAST_CLK) begin
          clk_cnt_n = '0;
          if (bit_idx == 3'd7) state_n = STOP;
          else                 bit_idx_n = bit_idx + 3'd1;
        end else begin
          clk_cnt_n = clk_cnt + BW'(1);
        end
      end
      STOP: begin
        if (clk_cnt == LAST_CLK) begin
          clk_cnt_n = '0;
          if (ci != 2'd3) begin
            ci_n    = ci + 2'd1;
            state_n = START;
          end else begin
            state_n = IDLE;
          end
        end else begin
          clk_cnt_n = clk_cnt + BW'(1);
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // tx is registered from the next-state view so the line changes exactly
  // on the cycle the FSM enters each bit.
  always_comb begin
    case (ci_n)
      2'd0:    ch_n = 8'h30 + h;
      2'd1:    ch_n = 8'h30 + t;
      2'd2:    ch_n = 8'h30 + u;
      default: ch_n = 8'h0A;
    endcase
    case (state_n)
      START:   tx_n = 1'b0;
      DATA:    tx_n = ch_n[bit_idx_n];
      default: tx_n = 1'b1;
    endcase
  end

endmodule

// File: tb/tb_avg_uart_tx.sv
// Self-checking bench for avg_uart_tx: a line-level UART monitor decodes tx
// and the decoded bytes are compared against "%03d\n" renderings of the inputs.
module tb_avg_uart_tx;

  localparam int CPB   = 4;
  localparam int DEPTH = 4;
  localparam int CW    = $clog2(DEPTH + 1);

  logic          clk = 1'b0;
  logic          rst;
  logic [7:0]    avg_in;
  logic          avg_valid;
  logic          tx;
  logic          busy;
  logic [CW-1:0] fifo_count;
  logic          overflow;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int rst_cnt = 0;

  byte unsigned rx_q[$];
  int           rx_start_q[$];
  byte unsigned exp_b[$];

  avg_uart_tx #(.CLKS_PER_BIT(CPB), .DEPTH(DEPTH)) dut (
    .clk       (clk),
    .rst       (rst),
    .avg_in    (avg_in),
    .avg_valid (avg_valid),
    .tx        (tx),
    .busy      (busy),
    .fifo_count(fifo_count),
    .overflow  (overflow)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (rst) rst_cnt <= rst_cnt + 1;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) @(negedge clk);
  endtask

  task automatic send(input logic [7:0] v);
    avg_in    = v;
    avg_valid = 1'b1;
    tick(1);
    avg_valid = 1'b0;
  endtask

  task automatic add_frame(input int v);
    string s;
    s = $sformatf("%03d\n", v);
    for (int k = 0; k < 4; k++) exp_b.push_back(s[k]);
  endtask

  task automatic clear_rx();
    rx_q.delete();
    rx_start_q.delete();
    exp_b.delete();
  endtask

  task automatic wait_idle(input string tag);
    int n;
    n = 0;
    while (busy !== 1'b0 && n < 2000) begin
      tick(1);
      n++;
    end
    check(tag, busy, 1'b0);
    tick(2);
  endtask

  task automatic compare_rx(input string tag);
    check({tag, "_len"}, rx_q.size(), exp_b.size());
    for (int i = 0; i < exp_b.size() && i < rx_q.size(); i++)
      check($sformatf("%s_byte%0d", tag, i), rx_q[i], exp_b[i]);
  endtask

  // Line monitor: a low level on an idle line opens a 10-bit character.
  logic [9:0] mon_bits;
  logic       mon_ok;
  int         mon_t0, mon_rst0;
  initial begin : monitor
    forever begin
      @(negedge clk);
      if (tx === 1'b0) begin
        mon_t0   = cyc;
        mon_rst0 = rst_cnt;
        mon_ok   = 1'b1;
        mon_bits = '0;
        for (int b = 0; b < 10; b++) begin
          for (int k = 0; k < CPB; k++) begin
            if (b != 0 || k != 0) @(negedge clk);
            if (k == 0) mon_bits[b] = tx;
            else if (tx !== mon_bits[b]) mon_ok = 1'b0;
          end
        end
        if (rst_cnt == mon_rst0) begin
          check("bit_width", mon_ok, 1'b1);
          check("stop_bit", mon_bits[9], 1'b1);
          rx_q.push_back(mon_bits[8:1]);
          rx_start_q.push_back(mon_t0);
        end
      end
    end
  end

  initial begin : stimulus
    int t0;
    int bad;
    int len;
    int v;
    int q[$];
    int exp_cnt[6];
    string s;

    exp_cnt = '{1, 1, 2, 3, 4, 4};
    rst = 1'b1;
    avg_valid = 1'b0;
    avg_in = '0;
    tick(3);
    check("rst_tx", tx, 1'b1);
    check("rst_busy", busy, 1'b0);
    check("rst_count", fifo_count, 0);
    check("rst_overflow", overflow, 1'b0);
    rst = 1'b0;
    tick(2);

    // Single value 123: latency, framing and busy fall time.
    clear_rx();
    t0 = cyc;
    send(8'd123);
    check("t1_count_n1", fifo_count, 1);
    check("t1_busy_n1", busy, 1'b1);
    tick(1);
    check("t1_count_n2", fifo_count, 0);
    check("t1_tx_n2", tx, 1'b1);
    tick(1);
    check("t1_tx_n3", tx, 1'b0);
    tick(159);
    check("t1_busy_n162", busy, 1'b1);
    tick(1);
    check("t1_busy_n163", busy, 1'b0);
    tick(2);
    add_frame(123);
    compare_rx("t1");
    check("t1_start", (rx_start_q.size() > 0) ? rx_start_q[0] - t0 : -1, 3);

    // 0 then 255 arriving mid-frame: frames back to back with a 2-cycle gap.
    clear_rx();
    send(8'd0);
    tick(50);
    send(8'd255);
    wait_idle("t2_idle");
    add_frame(0);
    add_frame(255);
    compare_rx("t2");
    check("t2_char_gap", (rx_start_q.size() >= 2) ? rx_start_q[1] - rx_start_q[0] : -1, 40);
    check("t2_frame_gap", (rx_start_q.size() >= 5) ? rx_start_q[4] - rx_start_q[0] : -1, 162);
    check("t2_overflow", overflow, 1'b0);

    // Push while full in the same cycle the idle FSM pops.
    clear_rx();
    q.delete();
    t0 = cyc;
    v = $urandom_range(0, 255);
    q.push_back(v);
    send(8'(v));
    tick(8);
    for (int i = 0; i < DEPTH; i++) begin
      v = $urandom_range(0, 255);
      q.push_back(v);
      send(8'(v));
    end
    while (cyc < t0 + 163) tick(1);
    check("t3_full_at_idle", fifo_count, DEPTH);
    v = $urandom_range(0, 255);
    q.push_back(v);
    send(8'(v));
    check("t3_count_after", fifo_count, DEPTH);
    check("t3_overflow", overflow, 1'b0);
    wait_idle("t3_idle");
    foreach (q[i]) add_frame(q[i]);
    compare_rx("t3");

    // Digit boundaries.
    clear_rx();
    q = '{9, 10, 99, 100, 199};
    foreach (q[i]) send(8'(q[i]));
    tick(200);
    send(8'd200);
    wait_idle("t4_idle");
    foreach (q[i]) add_frame(q[i]);
    add_frame(200);
    compare_rx("t4");

    // Random bursts that always fit (one popped immediately plus DEPTH queued).
    for (int r = 0; r < 3; r++) begin
      clear_rx();
      q.delete();
      len = $urandom_range(1, DEPTH + 1);
      for (int i = 0; i < len; i++) begin
        v = $urandom_range(0, 255);
        q.push_back(v);
        send(8'(v));
      end
      wait_idle($sformatf("t5_idle%0d", r));
      foreach (q[i]) add_frame(q[i]);
      compare_rx($sformatf("t5_r%0d", r));
      check($sformatf("t5_overflow%0d", r), overflow, 1'b0);
    end

    // Six consecutive pulses into DEPTH=4: the sixth is dropped.
    clear_rx();
    for (int i = 0; i < 6; i++) begin
      avg_in = 8'(10 + i);
      avg_valid = 1'b1;
      tick(1);
      check($sformatf("t6_count%0d", i), fifo_count, exp_cnt[i]);
      check($sformatf("t6_overflow%0d", i), overflow, (i == 5) ? 1'b1 : 1'b0);
    end
    avg_valid = 1'b0;
    wait_idle("t6_idle");
    for (int i = 0; i < 5; i++) add_frame(10 + i);
    compare_rx("t6");
    check("t6_ovf_sticky", overflow, 1'b1);

    // Reset during the data bits of the second character, two entries queued.
    clear_rx();
    t0 = cyc;
    v = $urandom_range(100, 255);
    send(8'(v));
    while (cyc < t0 + 5) tick(1);
    send(8'($urandom_range(0, 255)));
    send(8'($urandom_range(0, 255)));
    check("t7_queued", fifo_count, 2);
    while (cyc < t0 + 60) tick(1);
    rst = 1'b1;
    avg_in = 8'd77;
    avg_valid = 1'b1;
    tick(1);
    check("t7_tx", tx, 1'b1);
    check("t7_count", fifo_count, 0);
    check("t7_busy", busy, 1'b0);
    check("t7_overflow", overflow, 1'b0);
    rst = 1'b0;
    avg_valid = 1'b0;
    bad = 0;
    repeat (200) begin
      tick(1);
      if (tx !== 1'b1 || busy !== 1'b0 || fifo_count !== '0) bad++;
    end
    check("t7_quiet", bad, 0);
    s = $sformatf("%03d", v);
    exp_b.push_back(s[0]);
    compare_rx("t7");

    // Recovery after reset.
    clear_rx();
    v = $urandom_range(0, 255);
    send(8'(v));
    wait_idle("t8_idle");
    add_frame(v);
    compare_rx("t8");
    check("t8_overflow", overflow, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/avg_uart_tx.md
# avg_uart_tx

Downstream consumer of the temperature averager's once-per-minute result. Each pulse on `avg_valid` (driven by the averager's minute strobe) captures the 8-bit average into a small FIFO. The block then transmits the value as a fixed 4-character ASCII frame over a UART 8N1 line: three decimal digits, leading zeros kept, followed by LF (0x0A). It is the reporting end of the averaging path, feeding a host terminal.

## Interface
- `CLKS_PER_BIT`, 434, clock cycles per UART bit (50 MHz / 115200); legal range ≥ 2.
- `DEPTH`, 4, FIFO entries; power of two, ≥ 2.
- `clk`  input  1  single clock; all state changes on its rising edge.
- `rst`  input  1  reset, synchronous and active-high.
- `avg_in`  input  8  unsigned average, 0..255.
- `avg_valid`  input  1  one-cycle strobe; `avg_in` is sampled in the same cycle.
- `tx`  output  1  UART serial out; idle high.
- `busy`  output  1  high when the FIFO is non-empty or the FSM is not in IDLE.
- `fifo_count`  output  $clog2(DEPTH+1)  number of entries waiting in the FIFO.
- `overflow`  output  1  sticky; set when a push is dropped; cleared only by `rst`.

## Operation
- Reset values: `tx`=1, `busy`=0, `fifo_count`=0, `overflow`=0. FSM goes to IDLE and the FIFO pointers are cleared.
- FIFO push:
  - Occurs when `avg_valid`=1 and (count < DEPTH, or a pop happens in the same cycle).
  - Otherwise the push is dropped and `overflow` is set.
  - Simultaneous push and pop leaves count unchanged.
- FSM states: IDLE, CONV, START, DATA, STOP.
  - IDLE: `tx`=1. If count > 0: pop the head into `val`, go to CONV.
  - CONV (1 cycle): register the digits `h`=val/100, `t`=(val/10)%10, `u`=val%10. Set char index `ci`=0. Go to START.
  - START: `tx`=0 for CLKS_PER_BIT cycles, then go to DATA with bit index 0.
  - DATA: `tx`=char[bit], LSB first, each bit held CLKS_PER_BIT cycles. After bit 7, go to STOP.
  - STOP: `tx`=1 for CLKS_PER_BIT cycles. Then, if `ci`<3: increment `ci` and go to START (no gap). Otherwise go to IDLE.
- Character per `ci`: 0→0x30+h, 1→0x30+t, 2→0x30+u, 3→0x0A.
- Digit conversion: either combinational constant division or subtract-compare; the result must be valid within the CONV cycle. Values above 255 cannot occur.
- `tx` is a registered output (glitch-free).
- Reset mid-frame: `tx`=1 from the cycle after `rst` is sampled high, the FIFO is discarded, and `overflow` is cleared. No partial frame resumes.
- `avg_valid` during `rst` is ignored.

## Timing
- `avg_valid` sampled in cycle N with FSM idle and FIFO empty:
  - Entry is written at the end of N; `fifo_count`=1 in N+1.
  - Pop in N+1; `fifo_count`=0 in N+2.
  - CONV in N+2.
  - `tx`=0 first in cycle N+3.
- Frame duration: 40·CLKS_PER_BIT cycles from the first start bit to the end of the last stop bit.
- Back-to-back frames: IDLE and CONV add exactly 2 idle-high cycles between frames.
- `busy` rises in N+1. It falls in the first IDLE cycle with count=0.
- Bit boundaries: a bit-cycle counter runs 0..CLKS_PER_BIT-1 and the bit advances when the counter reaches CLKS_PER_BIT-1; there is no drift across a frame.

## Test plan
- CLKS_PER_BIT=4, single pulse with `avg_in`=123 at cycle N:
  - `tx` low at N+3.
  - Decoded bytes are 0x31, 0x32, 0x33, 0x0A, each bit 4 cycles wide.
  - `busy` low at N+3+160.
- `avg_in`=0, then 255 (second pulse mid-frame):
  - Frames "000\n" then "255\n".
  - Exactly 2 idle cycles between the two frames.
  - `overflow`=0.
- DEPTH=4, 6 consecutive pulses N..N+5 with values 10..15:
  - Value 10 popped at N+1.
  - Values 11..14 queued; `fifo_count`=4 at N+5.
  - Value 15 dropped; `overflow`=1 from N+6.
  - Frames "010\n".."014\n" transmitted in order.
- Pulse exactly when full and the FSM is popping (idle with count=DEPTH): push accepted, `fifo_count` stays DEPTH, `overflow` stays 0.
- `rst` asserted during the DATA bits of the second character, with 2 entries queued:
  - Next cycle: `tx`=1, `fifo_count`=0, `busy`=0, `overflow`=0.
  - No further start bit until a new pulse arrives.
- Digit boundaries 9, 10, 99, 100, 199, 200: frames "009\n", "010\n", "099\n", "100\n", "199\n", "200\n".
